s_axi_lite_regfile: RTL



---
 rtl/s_axi_lite_regfile.sv | 125 ++++++++++++
 1 files changed

// File: rtl/s_axi_lite_regfile.sv
// s_axi_lite_regfile: AXI4-Lite slave exposing P_NUM_REGS registers with byte strobes,
// read-only mask, decoupled AW/W acceptance and OKAY/SLVERR/DECERR responses.
module s_axi_lite_regfile #(
    parameter int P_S_AXI_DATA_WIDTH = 32,
    parameter int P_S_AXI_ADDR_WIDTH = 6,
    parameter int P_NUM_REGS = 8,
    parameter logic [P_NUM_REGS-1:0] P_RO_MASK = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [P_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [P_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [P_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [P_NUM_REGS*P_S_AXI_DATA_WIDTH-1:0] o_reg_data,
    input  logic [P_NUM_REGS*P_S_AXI_DATA_WIDTH-1:0] i_ro_data,
    output logic [P_NUM_REGS-1:0]                    o_wr_pulse
);
    localparam int DW = P_S_AXI_DATA_WIDTH;
    localparam int AW = P_S_AXI_ADDR_WIDTH;
    localparam int NB = DW / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW = AW - LSB;

    logic                  aw_held, w_held, aw_held_n, w_held_n;
    logic                  aw_hs, w_hs, ar_hs, commit, rvalid_n;
    logic [IW-1:0]         aw_idx, ar_idx;
    logic [DW-1:0]         w_data, rd_val;
    logic [NB-1:0]         w_strb;
    logic [P_NUM_REGS-1:0] wr_sel;
    logic [1:0]            wr_resp, rd_resp;
    logic [DW-1:0]         regs [P_NUM_REGS];
    logic                  unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0], i_ro_data};

    assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit    = aw_held & w_held & (~S_AXI_BVALID | S_AXI_BREADY);
    assign aw_held_n = aw_hs | (aw_held & ~commit);
    assign w_held_n  = w_hs | (w_held & ~commit);
    assign rvalid_n  = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);
    assign ar_idx    = S_AXI_ARADDR[AW-1:LSB];

    // Indices with no matching register fall through to the DECERR defaults.
    always_comb begin
        wr_sel  = '0;
        wr_resp = 2'b11;
        rd_val  = '0;
        rd_resp = 2'b11;
        for (int i = 0; i < P_NUM_REGS; i++) begin
            if (aw_idx == IW'(i)) begin
                wr_sel[i] = ~P_RO_MASK[i];
                wr_resp   = P_RO_MASK[i] ? 2'b10 : 2'b00;
            end
            if (ar_idx == IW'(i)) begin
                rd_val  = P_RO_MASK[i] ? i_ro_data[i*DW +: DW] : regs[i];
                rd_resp = 2'b00;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            o_wr_pulse    <= '0;
            for (int i = 0; i < P_NUM_REGS; i++) regs[i] <= '0;
        end else begin
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            S_AXI_AWREADY <= ~aw_held_n;
            S_AXI_WREADY  <= ~w_held_n;
            if (aw_hs) aw_idx <= S_AXI_AWADDR[AW-1:LSB];
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            S_AXI_BVALID <= commit | (S_AXI_BVALID & ~S_AXI_BREADY);
            if (commit) S_AXI_BRESP <= wr_resp;
            o_wr_pulse <= commit ? wr_sel : '0;
            for (int i = 0; i < P_NUM_REGS; i++)
                for (int b = 0; b < NB; b++)
                    if (commit && wr_sel[i] && w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
            // Read data is captured at the AR handshake, so a same-edge write is not visible.
            S_AXI_RVALID  <= rvalid_n;
            S_AXI_ARREADY <= ~rvalid_n;
            if (ar_hs) begin
                S_AXI_RDATA <= rd_val;
                S_AXI_RRESP <= rd_resp;
            end
        end
    end

    for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_out
        assign o_reg_data[g*DW +: DW] = regs[g];
    end
endmodule
